mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Iterative signed multiply/divide unit for the multicycle MIPS datapath. Consumes the two
//   register-bank read ports (rs, rt) on a start strobe from the control unit and produces the
//   HI/LO registers that feed inputs 2/3 of the register write-data mux (mfhi/mflo).
//   Multiplication is radix-2 Booth, division is signed restoring; one bit per clock.
// PARAMETERS
//   WIDTH  32  operand width; hi/lo are WIDTH bits each, product is 2*WIDTH bits
// PORTS
//   clock       in   1      system clock, all state updates on rising edge
//   reset       in   1      synchronous, active-low reset
//   start_mult  in   1      strobe: begin signed a*b (sampled only when idle)
//   start_div   in   1      strobe: begin signed a/b (sampled only when idle)
//   a           in   WIDTH  operand rs (multiplicand / dividend)
//   b           in   WIDTH  operand rt (multiplier / divisor)
//   busy        out  1      operation in progress; control must hold in wait state
//   done        out  1      one-cycle pulse: hi/lo valid (or div_zero set) this cycle
//   div_zero    out  1      last division had b==0; held until next accepted start
//   hi          out  WIDTH  mult: product[2W-1:W]; div: remainder
//   lo          out  WIDTH  mult: product[W-1:0];  div: quotient
// BEHAVIOUR
//   - Reset (reset==0 at an edge): state IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0,
//     counter=0; aborts any operation in progress, no partial result reaches hi/lo.
//   - States: IDLE -> MULT | DIV -> FINISH -> IDLE.
//   - IDLE: start_mult=1 -> MULT; else start_div=1 -> DIV; both high -> MULT, div ignored.
//     a and b captured on the accepting edge E0; later changes on a/b have no effect.
//     div_zero cleared on E0 of every accepted start.
//   - Starts while busy=1 are ignored (no queuing, no error).
//   - MULT: Booth step per edge E1..EWIDTH on {acc,q,q-1}; arithmetic shift right of the
//     2W+1-bit register; counter 0..WIDTH-1.
//   - DIV: operands converted to magnitudes at E0, signs saved; restoring step per edge
//     E1..EWIDTH; b==0 detected at E0 -> skip iterations, go straight to FINISH at E1.
//   - FINISH (edge after last step): hi/lo written, done=1 for exactly that cycle, busy=0,
//     state IDLE. Latency: result visible WIDTH+1 edges after E0 (33 for WIDTH=32);
//     div-by-zero: visible after 1 edge, hi/lo unchanged, div_zero=1.
//   - busy=1 from the cycle after E0 until the cycle done pulses (done and busy never both 1).
//   - A new start may be accepted on the same edge that done is high (back-to-back).
//   - Div sign rules: quotient truncated toward zero; remainder takes dividend's sign;
//     quotient negated if signs differ. -2^(W-1) / -1 -> lo=0x80000000, hi=0 (no trap).
//   - Mult: {hi,lo} = full signed 2W-bit product, no overflow possible.
//   - hi/lo hold their value between operations; only FINISH or reset modifies them.
// TESTING
//   1. reset low 1 cycle mid-MULT at step 10 -> busy=0, done never pulses, hi=lo=0.
//   2. start_mult a=7 b=-3 -> 33 edges later done=1, hi=0xFFFFFFFF lo=0xFFFFFFEB.
//   3. start_mult a=0x80000000 b=0x80000000 -> hi=0x40000000 lo=0x00000000.
//   4. start_div a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); div a=0x80000000
//      b=-1 -> lo=0x80000000 hi=0.
//   5. start_div a=5 b=0 with hi/lo=prev -> 1 edge later done=1, div_zero=1, hi/lo unchanged;
//      next start_mult clears div_zero.
//   6. start_mult and start_div same cycle, then start_div pulsed while busy -> only
//      multiply result produced, single done pulse; start on done cycle accepted.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit, one bit per clock.
// Produces HI/LO for mfhi/mflo; a single done pulse marks each completed operation.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q1_q, q1_d;
  logic             is_div_q, is_div_d;
  logic             dz_q, dz_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             last_step;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign last_step = (cnt_q == CW'(WIDTH - 1));
  assign a_mag     = a[WIDTH-1] ? -a : a;
  assign b_mag     = b[WIDTH-1] ? -b : b;

  // state register
  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_mult)     state_d = MULT;
        else if (start_div) state_d = (b == '0) ? FINISH : DIV;
      end
      MULT, DIV: if (last_step) state_d = FINISH;
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy     = (state_q != IDLE);
    done     = done_q;
    div_zero = div_zero_q;
    hi       = hi_q;
    lo       = lo_q;
  end

  always_comb begin
    case ({q_q[0], q1_q})
      2'b01:   booth_sum = acc_q + m_q;
      2'b10:   booth_sum = acc_q - m_q;
      default: booth_sum = acc_q;
    endcase
    div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    div_trial = div_shift - m_q;
  end

  // datapath next-state
  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    m_d        = m_q;
    q_d        = q_q;
    q1_d       = q1_q;
    is_div_d   = is_div_q;
    dz_d       = dz_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      IDLE: begin
        if (start_mult || start_div) begin
          cnt_d      = '0;
          acc_d      = '0;
          q1_d       = 1'b0;
          div_zero_d = 1'b0;
          is_div_d   = !start_mult;
          dz_d       = !start_mult && (b == '0);
          neg_quot_d = a[WIDTH-1] ^ b[WIDTH-1];
          neg_rem_d  = a[WIDTH-1];
          if (start_mult) begin
            m_d = {a[WIDTH-1], a};
            q_d = b;
          end else begin
            m_d = {1'b0, b_mag};
            q_d = a_mag;
          end
        end
      end
      MULT: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
        q1_d  = q_q[0];
      end
      DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (!div_trial[WIDTH]) begin
          acc_d = div_trial;
          q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = div_shift;
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
      end
      FINISH: begin
        done_d = 1'b1;
        if (is_div_q && dz_q) begin
          div_zero_d = 1'b1;
        end else if (is_div_q) begin
          lo_d = neg_quot_q ? -q_q : q_q;
          hi_d = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end else begin
          hi_d = acc_q[WIDTH-1:0];
          lo_d = q_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      m_q        <= '0;
      q_q        <= '0;
      q1_q       <= 1'b0;
      is_div_q   <= 1'b0;
      dz_q       <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      m_q        <= m_d;
      q_q        <= q_d;
      q1_q       <= q1_d;
      is_div_q   <= is_div_d;
      dz_q       <= dz_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a plain-arithmetic reference model.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start_mult, start_div;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int           n_tests = 0;
  int           n_fail  = 0;

  logic [W-1:0] exp_hi = '0, exp_lo = '0;
  logic         exp_dz = 1'b0;
  int           exp_lat = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model: expected hi/lo/div_zero/latency from signed 64-bit arithmetic.
  task automatic launch(input bit is_div, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit both);
    longint       sa, sb, qv, rv;
    logic [63:0]  p;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    start_mult = !is_div || both;
    start_div  = is_div || both;
    a = av;
    b = bv;
    if (!is_div || both) begin
      p = sa * sb;
      exp_hi = p[63:32];
      exp_lo = p[31:0];
      exp_dz = 1'b0;
      exp_lat = W + 1;
    end else if (bv == '0) begin
      exp_dz = 1'b1;
      exp_lat = 1;
    end else begin
      qv = sa / sb;
      rv = sa % sb;
      exp_lo = qv[31:0];
      exp_hi = rv[31:0];
      exp_dz = 1'b0;
      exp_lat = W + 1;
    end
  endtask

  task automatic finish_op(input string tag, input bit poke);
    int  n;
    bit  busy_bad;
    @(posedge clock); #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a = $urandom;
    b = $urandom;
    chk({tag, "_busy_e0"}, busy, 1);
    chk({tag, "_dz_clr"}, div_zero, 0);
    n = 0;
    busy_bad = 0;
    while (!done && n < 40) begin
      if (poke && n == 5) begin
        start_div  = 1'b1;
        start_mult = 1'b1;
      end else begin
        start_div  = 1'b0;
        start_mult = 1'b0;
      end
      @(posedge clock); #1;
      n++;
      if (!done && !busy) busy_bad = 1;
    end
    start_div  = 1'b0;
    start_mult = 1'b0;
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_busy_low"}, {busy_bad, busy}, 0);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_divzero"}, div_zero, exp_dz);
  endtask

  task automatic run_op(input string tag, input bit is_div, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input bit both, input bit poke);
    @(negedge clock);
    launch(is_div, av, bv, both);
    finish_op(tag, poke);
  endtask

  task automatic check_idle(input string tag);
    @(posedge clock); #1;
    chk({tag, "_done_once"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int pulses;
    logic [W-1:0] ra, rb;
    reset = 1'b0;
    start_mult = 1'b0;
    start_div = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hilo", {hi, lo}, 0);
    chk("rst_dz", div_zero, 0);
    @(negedge clock);
    reset = 1'b1;

    run_op("mul_7_m3", 0, 32'd7, 32'hFFFF_FFFD, 0, 0);
    check_idle("mul_7_m3");
    run_op("mul_min", 0, 32'h8000_0000, 32'h8000_0000, 0, 0);
    run_op("div_m7_2", 1, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op("div_min_m1", 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("div_by0", 1, 32'd5, 32'd0, 0, 0);
    check_idle("div_by0");
    run_op("mul_after0", 0, 32'd12345, 32'hFFFF_0000, 0, 0);
    run_op("both_poke", 0, 32'hDEAD_BEEF, 32'h0000_1234, 1, 1);
    check_idle("both_poke");
    // back-to-back: the next start is driven during the done cycle
    run_op("b2b_first", 1, 32'd1000, 32'hFFFF_FFF9, 0, 0);
    launch(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
    finish_op("b2b_second", 0);
    check_idle("b2b_second");

    // reset during a multiply at step 10
    @(negedge clock);
    launch(0, 32'h1234_5678, 32'h0FED_CBA9, 0);
    @(posedge clock); #1;
    start_mult = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    exp_dz = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_hilo", {hi, lo}, 0);
    pulses = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) pulses++;
    end
    chk("abort_nodone", pulses, 0);
    chk("abort_hilo_after", {hi, lo}, 0);

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = $urandom_range(0, 3);
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: ra = $urandom_range(0, 100);
        default: ;
      endcase
      run_op((i % 2) ? "rnd_div" : "rnd_mul", bit'(i % 2), ra, rb, 0, bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
